uart_word_matcher: RTL and testbench

- Parametrised successor to the fixed single-word UART detector.
- Consumes the received byte stream from the UART receiver and keeps a sliding window of the last WORD_LEN characters. It compares that window against a compile-time target word.
- On a match it raises a timed "matched" indication and bumps a saturating match counter, and drives ASCII display data for the downstream 7-segment encoder.
- The sliding window makes overlapping and repeated prefixes (e.g. "HHELLO", "HELHELLO") match correctly, with no per-letter state chain.

---
 rtl/uart_word_matcher.sv | 116 +++++++++++
 tb/tb_uart_word_matcher.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_word_matcher.sv
// Sliding-window word detector on a UART byte stream, with a retriggerable hold timer,
// a saturating match counter and ASCII output for a 7-segment display encoder.
module uart_word_matcher #(
  parameter int                    WORD_LEN    = 5,
  parameter logic [WORD_LEN*8-1:0] WORD        = "HELLO",
  parameter bit                    CASE_INSENS = 1'b1,
  parameter bit                    FILTER_CTRL = 1'b1,
  parameter int                    HOLD_CYCLES = 50000000,
  parameter int                    DISP_DIGITS = 6,
  parameter int                    CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     clear,
  output logic                     match_pulse,
  output logic                     matched,
  output logic [CNT_W-1:0]         match_count,
  output logic [DISP_DIGITS*8-1:0] disp_data
);

  localparam int TW = $clog2(HOLD_CYCLES + 1);

  if (WORD_LEN < 1 || WORD_LEN > DISP_DIGITS || HOLD_CYCLES < 1) begin : g_bad_param
    $error("uart_word_matcher: need 1 <= WORD_LEN <= DISP_DIGITS and HOLD_CYCLES >= 1");
  end

  function automatic logic [7:0] fold(input logic [7:0] b);
    if (CASE_INSENS && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  function automatic logic [WORD_LEN*8-1:0] fold_word(input logic [WORD_LEN*8-1:0] w);
    logic [WORD_LEN*8-1:0] r;
    for (int i = 0; i < WORD_LEN; i++) r[i*8 +: 8] = fold(w[i*8 +: 8]);
    return r;
  endfunction

  localparam logic [WORD_LEN*8-1:0] WORD_F = fold_word(WORD);

  function automatic logic [DISP_DIGITS*8-1:0] hold_disp();
    logic [DISP_DIGITS*8-1:0] d;
    d = {DISP_DIGITS{8'h2E}};
    d[WORD_LEN*8-1:0] = WORD_F;
    return d;
  endfunction

  localparam logic [DISP_DIGITS*8-1:0] HOLD_DISP = hold_disp();

  typedef enum logic {HUNT, HOLD} state_t;

  state_t                   state, state_n;
  logic [TW-1:0]            timer, timer_n;
  logic [DISP_DIGITS*8-1:0] hist, hist_n;
  logic [7:0]               byte_f;
  logic                     accept, hit;

  // The match window is simply the newest WORD_LEN bytes of the display history.
  always_comb begin
    byte_f     = fold(rx_data);
    accept     = rx_valid && !clear && (!FILTER_CTRL || rx_data >= 8'h20);
    hist_n     = hist << 8;
    hist_n[7:0] = byte_f;
    hit        = accept && (hist_n[WORD_LEN*8-1:0] == WORD_F);
    state_n    = state;
    timer_n    = timer;
    case (state)
      HUNT: if (hit) begin
        state_n = HOLD;
        timer_n = TW'(HOLD_CYCLES - 1);
      end
      HOLD: begin
        if (hit)              timer_n = TW'(HOLD_CYCLES - 1);
        else if (timer == '0) state_n = HUNT;
        else                  timer_n = timer - TW'(1);
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      timer       <= '0;
      hist        <= '0;
      match_pulse <= 1'b0;
      match_count <= '0;
    end else if (clear) begin
      state       <= HUNT;
      timer       <= '0;
      hist        <= '0;
      match_pulse <= 1'b0;
      match_count <= '0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      match_pulse <= hit;
      if (accept) hist <= hist_n;
      if (hit && match_count != '1) match_count <= match_count + CNT_W'(1);
    end
  end

  assign matched = (state == HOLD);

  // Digits never written (0x00) show as blanks.
  always_comb begin
    disp_data = '0;
    for (int d = 0; d < DISP_DIGITS; d++) begin
      if (state == HOLD)              disp_data[d*8 +: 8] = HOLD_DISP[d*8 +: 8];
      else if (hist[d*8 +: 8] == '0) disp_data[d*8 +: 8] = 8'h20;
      else                            disp_data[d*8 +: 8] = hist[d*8 +: 8];
    end
  end

endmodule

// File: tb/tb_uart_word_matcher.sv
// Scoreboard bench: two matcher configurations share one byte stream; the stimulus pushes
// expected counts per match and a negedge monitor pops them on every match_pulse.
module tb_uart_word_matcher;

  logic        clk = 1'b0;
  logic        rst, clear, rx_valid;
  logic [7:0]  rx_data;
  logic        pulse_a, matched_a, pulse_b, matched_b;
  logic [7:0]  count_a;
  logic [1:0]  count_b;
  logic [47:0] disp_a, disp_b;

  int n_vec = 0, n_bad = 0;
  int qa[$], qb[$];
  int exp_a = 0, exp_b = 0;
  int run = 0, last_run = 0, pulses_b = 0;

  always #5 clk = ~clk;

  uart_word_matcher #(.HOLD_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .clear(clear),
    .match_pulse(pulse_a), .matched(matched_a), .match_count(count_a), .disp_data(disp_a));

  uart_word_matcher #(.HOLD_CYCLES(8), .CASE_INSENS(1'b0), .FILTER_CTRL(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .clear(clear),
    .match_pulse(pulse_b), .matched(matched_b), .match_count(count_b), .disp_data(disp_b));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // hits_a/hits_b: bit i set when char i completes a match in that configuration.
  // gap=0 sends a back-to-back burst; gap=2 spaces strobes 4 cycles apart.
  task automatic send_str(input string s, input int gap, input int hits_a, input int hits_b);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge clk); #1;
      rx_data = s[i];
      rx_valid = 1'b1;
      if ((hits_a >> i) & 1) begin exp_a++; qa.push_back(exp_a); end
      if ((hits_b >> i) & 1) begin exp_b = (exp_b < 3) ? exp_b + 1 : 3; qb.push_back(exp_b); end
      if (gap > 0) begin
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
      end
    end
    if (rx_valid) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pulse_a) begin
        if (qa.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL pulse_a: got unexpected pulse, expected none");
        end else begin
          chk("count_a", count_a, qa.pop_front());
          chk("matched_a_at_pulse", matched_a, 1);
          chk("hold_disp_a", disp_a, {8'h2E, "HELLO"});
        end
      end
      if (pulse_b) begin
        pulses_b++;
        if (qb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL pulse_b: got unexpected pulse, expected none");
        end else begin
          chk("count_b", count_b, qb.pop_front());
          chk("matched_b_at_pulse", matched_b, 1);
        end
      end
    end
  end

  // Length of the most recent continuous matched_a run, in cycles.
  always @(negedge clk) begin
    if (rst) run = 0;
    else if (matched_a) run++;
    else if (run != 0) begin last_run = run; run = 0; end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    chk("rst_matched", matched_a, 0);
    chk("rst_pulse", pulse_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_disp", disp_a, 48'h2020_2020_2020);
    chk("rst_disp_b", disp_b, 48'h2020_2020_2020);
    rst = 1'b0;

    send_str("HELLO", 2, 16, 16);
    idle(12);
    chk("hold_len", last_run, 8);
    chk("hist_disp", disp_a, {8'h20, "HELLO"});

    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    exp_a = 0; exp_b = 0; pulses_b = 0;
    chk("clear_count", count_a, 0);

    send_str("HELHELLO", 2, 128, 128);
    send_str("HHELLO", 2, 32, 32);
    send_str("HELO", 2, 0, 0);
    send_str("HELLLO", 2, 0, 0);
    idle(12);
    chk("overlap_count_a", count_a, 2);
    chk("overlap_count_b", count_b, 2);

    send_str("hello", 2, 16, 0);
    #1;
    chk("lower_disp_b", disp_b[39:0], "hello");

    send_str("HEL\015\012LO", 2, 64, 0);
    idle(12);
    chk("filter_count_a", count_a, 4);
    chk("nofilter_count_b", count_b, 2);

    send_str("HELLOHELLO", 0, 528, 528);
    idle(16);
    chk("retrig_len", last_run, 13);
    chk("retrig_count_a", count_a, 6);

    send_str("HELLO", 2, 16, 16);
    idle(12);
    chk("sat_count_b", count_b, 3);
    chk("sat_pulses_b", pulses_b, 5);
    chk("count_a_7", count_a, 7);

    send_str("HELLOHELL", 0, 16, 16);
    @(posedge clk); #1;
    rx_data = "O"; rx_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; clear = 1'b0;
    exp_a = 0; exp_b = 0;
    chk("clr_matched_a", matched_a, 0);
    chk("clr_count_a", count_a, 0);
    chk("clr_disp_a", disp_a, 48'h2020_2020_2020);
    chk("clr_matched_b", matched_b, 0);
    chk("clr_count_b", count_b, 0);

    send_str("HELLO", 2, 16, 16);
    chk("pre_rst_matched", matched_a, 1);
    @(negedge clk); #1 rst = 1'b1;
    #1;
    chk("async_rst_matched_a", matched_a, 0);
    chk("async_rst_matched_b", matched_b, 0);
    chk("async_rst_count", count_a, 0);
    #1 rst = 1'b0;
    exp_a = 0; exp_b = 0;

    idle(5);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
